alien_dir_scanner: RTL



---
 rtl/alien_dir_scanner.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alien_dir_scanner.sv
// Per-frame open-direction scanner for one alien: reads the four neighbour cells of the
// tunnel map when grid-aligned, otherwise derives directions from alignment. Macro: ALIEN_SCAN_EDGE_EN.
module alien_dir_scanner #(
    parameter int MAP_COLS   = 20,
    parameter int MAP_ROWS   = 15,
    parameter int CELL_SHIFT = 5,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic [10:0]       alien_topLeftX,
    input  logic [10:0]       alien_topLeftY,
    output logic              map_rd_en,
    output logic [ADDR_W-1:0] map_addr,
    input  logic              map_rdata,
    output logic [3:0]        free_direction,
    output logic [3:0]        HitEdgeCode,
    output logic              dir_valid,
    output logic              busy
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic signed [11:0] ColsS = 12'(MAP_COLS);
    localparam logic signed [11:0] RowsS = 12'(MAP_ROWS);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StRdUp,
        StRdRight,
        StRdDown,
        StRdLeft,
        StFlush,
        StUpdate
    } state_e;

    state_e            state_q, state_d;
    logic [10:0]       x_q, x_d, y_q, y_d;
    logic [3:0]        free_w_q, free_w_d;
    logic [3:0]        free_q, free_d;
    logic              pend_q, pend_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef ALIEN_SCAN_EDGE_EN
    logic [3:0]        edge_w_q, edge_w_d;
    logic [3:0]        hit_q, hit_d;
`endif

    logic signed [11:0] x_ext, y_ext, col_c, row_c, nb_col, nb_row;
    logic               ax, ay, in_map, nb_oob, rd_state;
    logic [AW1-1:0]     addr_full;
    logic [ADDR_W-1:0]  addr_trunc;

    // Position is sampled live during LATCH and held for the rest of the scan.
    assign x_d   = (state_q == StLatch) ? alien_topLeftX : x_q;
    assign y_d   = (state_q == StLatch) ? alien_topLeftY : y_q;
    assign x_ext = {x_d[10], x_d};
    assign y_ext = {y_d[10], y_d};
    assign col_c = x_ext >>> CELL_SHIFT;
    assign row_c = y_ext >>> CELL_SHIFT;
    assign ax    = (x_d[CELL_SHIFT-1:0] == '0);
    assign ay    = (y_d[CELL_SHIFT-1:0] == '0);
    assign in_map = !x_d[10] && !y_d[10] && (col_c < ColsS) && (row_c < RowsS);

    always_comb begin
        nb_col = col_c;
        nb_row = row_c;
        case (state_q)
            StRdUp:    nb_row = row_c - 12'sd1;
            StRdRight: nb_col = col_c + 12'sd1;
            StRdDown:  nb_row = row_c + 12'sd1;
            StRdLeft:  nb_col = col_c - 12'sd1;
            default: ;
        endcase
    end

    assign nb_oob = (nb_col < 12'sd0) || (nb_col >= ColsS) ||
                    (nb_row < 12'sd0) || (nb_row >= RowsS);
    assign rd_state = (state_q == StRdUp) || (state_q == StRdRight) ||
                      (state_q == StRdDown) || (state_q == StRdLeft);

    // Bounds are already checked, so the narrow multiply cannot alias a valid cell.
    assign addr_full  = AW1'(nb_row) * AW1'(MAP_COLS) + AW1'(nb_col);
    assign addr_trunc = ADDR_W'(addr_full);

    assign map_rd_en = rd_state && !nb_oob;
    assign addr_d    = map_rd_en ? addr_trunc : addr_q;
    assign map_addr  = addr_d;

    always_comb begin
        state_d  = state_q;
        free_w_d = free_w_q;
        pend_d   = 1'b0;
        free_d   = free_q;
        valid_d  = 1'b0;
`ifdef ALIEN_SCAN_EDGE_EN
        edge_w_d = edge_w_q;
        hit_d    = hit_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (startOfFrame) state_d = StLatch;
            end
            StLatch: begin
                free_w_d = '0;
`ifdef ALIEN_SCAN_EDGE_EN
                edge_w_d = '0;
`endif
                state_d = StUpdate;
                if (in_map) begin
                    if (ax && ay) begin
                        state_d = StRdUp;
                    end else if (ay) begin
                        free_w_d = 4'b0101;
`ifdef ALIEN_SCAN_EDGE_EN
                        if (col_c == 12'sd0) begin
                            free_w_d[0] = 1'b0;
                            edge_w_d[0] = 1'b1;
                        end
                        if (col_c + 12'sd1 >= ColsS) begin
                            free_w_d[2] = 1'b0;
                            edge_w_d[2] = 1'b1;
                        end
`endif
                    end else if (ax) begin
                        free_w_d = 4'b1010;
`ifdef ALIEN_SCAN_EDGE_EN
                        if (row_c == 12'sd0) begin
                            free_w_d[3] = 1'b0;
                            edge_w_d[3] = 1'b1;
                        end
                        if (row_c + 12'sd1 >= RowsS) begin
                            free_w_d[1] = 1'b0;
                            edge_w_d[1] = 1'b1;
                        end
`endif
                    end
                end
            end
            // Each RD state issues its own read and captures the previous direction's data.
            StRdUp: begin
                pend_d  = map_rd_en;
                state_d = StRdRight;
`ifdef ALIEN_SCAN_EDGE_EN
                if (nb_oob) edge_w_d[3] = 1'b1;
`endif
            end
            StRdRight: begin
                free_w_d[3] = pend_q & map_rdata;
                pend_d      = map_rd_en;
                state_d     = StRdDown;
`ifdef ALIEN_SCAN_EDGE_EN
                if (nb_oob) edge_w_d[2] = 1'b1;
`endif
            end
            StRdDown: begin
                free_w_d[2] = pend_q & map_rdata;
                pend_d      = map_rd_en;
                state_d     = StRdLeft;
`ifdef ALIEN_SCAN_EDGE_EN
                if (nb_oob) edge_w_d[1] = 1'b1;
`endif
            end
            StRdLeft: begin
                free_w_d[1] = pend_q & map_rdata;
                pend_d      = map_rd_en;
                state_d     = StFlush;
`ifdef ALIEN_SCAN_EDGE_EN
                if (nb_oob) edge_w_d[0] = 1'b1;
`endif
            end
            StFlush: begin
                free_w_d[0] = pend_q & map_rdata;
                state_d     = StUpdate;
            end
            StUpdate: begin
                free_d  = free_w_q;
                valid_d = 1'b1;
                state_d = StIdle;
`ifdef ALIEN_SCAN_EDGE_EN
                hit_d   = edge_w_q;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            free_w_q <= '0;
            free_q   <= '0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
`ifdef ALIEN_SCAN_EDGE_EN
            edge_w_q <= '0;
            hit_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            free_w_q <= free_w_d;
            free_q   <= free_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
`ifdef ALIEN_SCAN_EDGE_EN
            edge_w_q <= edge_w_d;
            hit_q    <= hit_d;
`endif
        end
    end

    assign free_direction = free_q;
    assign dir_valid      = valid_q;
    assign busy           = (state_q != StIdle);
`ifdef ALIEN_SCAN_EDGE_EN
    assign HitEdgeCode    = hit_q;
`else
    assign HitEdgeCode    = 4'b0000;
`endif

endmodule
